// File: rtl/quadrant_pixel_uart_tx_pkg.sv
// Shared constants for the quadrant pixel UART transmitter: UART framing,
// sync header, grid geometry and the packet FSM state encoding.
package quadrant_pixel_uart_tx_pkg;

  localparam int S_DATA     = 16;
  localparam int S_ADDR     = 2;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int GRID       = 3;

  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  localparam logic [7:0] HEADER_SYNC = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_FETCH,
    ST_WAIT_RAM,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/quadrant_pixel_uart_tx_if.sv
// Control handshake, capture-RAM read port and UART line of the pixel sender.
interface quadrant_pixel_uart_tx_if import quadrant_pixel_uart_tx_pkg::*; ();

  logic              partida;
  logic [S_DATA-1:0] pixel;
  logic [S_ADDR-1:0] addr_line;
  logic [S_ADDR-1:0] addr_column;
  logic              tx;
  logic              ocupado;
  logic              pronto;

  modport master (
    output partida, pixel,
    input  addr_line, addr_column, tx, ocupado, pronto
  );

  modport slave (
    input  partida, pixel,
    output addr_line, addr_column, tx, ocupado, pronto
  );

endinterface

// File: rtl/quadrant_pixel_uart_tx_byte.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles. pronto_byte marks the last stop-bit cycle.
module uart_tx_byte import quadrant_pixel_uart_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [7:0] dado,
  output logic       tx,
  output logic       pronto_byte
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]   baud_cnt_reg;
  logic [3:0]         bit_idx_reg;
  logic [DATA_BITS:0] shift_reg;
  logic               busy_reg;
  logic               tx_reg;
  logic               bit_end;

  assign bit_end     = busy_reg && (baud_cnt_reg == CNT_LAST);
  assign pronto_byte = bit_end && (bit_idx_reg == IDX_LAST);
  assign tx          = tx_reg;

  // shift_reg holds the bits still to go out after the current one, stop bit last
  always_ff @(posedge clock) begin
    if (!reset) begin
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '1;
      busy_reg     <= 1'b0;
      tx_reg       <= UART_STOP;
    end else if (!busy_reg) begin
      if (envia) begin
        busy_reg     <= 1'b1;
        shift_reg    <= {UART_STOP, dado};
        tx_reg       <= UART_START;
        baud_cnt_reg <= '0;
        bit_idx_reg  <= '0;
      end
    end else if (bit_end) begin
      baud_cnt_reg <= '0;
      if (bit_idx_reg == IDX_LAST) begin
        busy_reg    <= 1'b0;
        tx_reg      <= UART_STOP;
        bit_idx_reg <= '0;
      end else begin
        bit_idx_reg <= bit_idx_reg + 1'b1;
        tx_reg      <= shift_reg[0];
        shift_reg   <= {UART_STOP, shift_reg[DATA_BITS:1]};
      end
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/quadrant_pixel_uart_tx.sv
// Reads the 3x3 pixel grid from the capture RAM and sends it over UART as
// a 19-byte packet: sync header, then each pixel high byte then low byte.
module quadrant_pixel_uart_tx import quadrant_pixel_uart_tx_pkg::*; #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = HEADER_SYNC
) (
  input logic clock,
  input logic reset,
  quadrant_pixel_uart_tx_if.slave bus
);

  localparam logic [S_ADDR-1:0] LAST_IDX = S_ADDR'(GRID - 1);

  state_t            state_reg;
  logic [S_ADDR-1:0] line_reg;
  logic [S_ADDR-1:0] col_reg;
  logic [S_DATA-1:0] shadow_reg;
  logic              envia_reg;
  logic              ocupado_reg;
  logic              pronto_reg;
  logic [7:0]        dado;
  logic              pronto_byte;

  // The high byte is handed over straight from the RAM in WAIT_RAM, on the
  // same edge the shadow captures it, to keep the inter-byte gap short.
  always_comb begin
    dado = HEADER;
    case (state_reg)
      ST_WAIT_RAM: dado = bus.pixel[S_DATA-1 -: 8];
      ST_SEND_HI:  dado = shadow_reg[S_DATA-1 -: 8];
      ST_SEND_LO:  dado = shadow_reg[7:0];
      default:     dado = HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      line_reg    <= '0;
      col_reg     <= '0;
      shadow_reg  <= '0;
      envia_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
      pronto_reg  <= 1'b0;
    end else begin
      envia_reg  <= 1'b0;
      pronto_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.partida) begin
            state_reg   <= ST_SEND_HDR;
            ocupado_reg <= 1'b1;
            envia_reg   <= 1'b1;
          end
        end
        ST_SEND_HDR: if (pronto_byte) state_reg <= ST_FETCH;
        // address is already on the RAM port; arm the sender for WAIT_RAM
        ST_FETCH: begin
          state_reg <= ST_WAIT_RAM;
          envia_reg <= 1'b1;
        end
        ST_WAIT_RAM: begin
          shadow_reg <= bus.pixel;
          state_reg  <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (pronto_byte) begin
            state_reg <= ST_SEND_LO;
            envia_reg <= 1'b1;
          end
        end
        ST_SEND_LO: if (pronto_byte) state_reg <= ST_NEXT;
        ST_NEXT: begin
          state_reg <= ST_FETCH;
          if (col_reg == LAST_IDX) begin
            col_reg <= '0;
            if (line_reg == LAST_IDX) begin
              line_reg    <= '0;
              state_reg   <= ST_DONE;
              pronto_reg  <= 1'b1;
              ocupado_reg <= 1'b0;
            end else begin
              line_reg <= line_reg + 1'b1;
            end
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock      (clock),
    .reset      (reset),
    .envia      (envia_reg),
    .dado       (dado),
    .tx         (bus.tx),
    .pronto_byte(pronto_byte)
  );

  assign bus.addr_line   = line_reg;
  assign bus.addr_column = col_reg;
  assign bus.ocupado     = ocupado_reg;
  assign bus.pronto      = pronto_reg;

endmodule

// File: tb/tb_quadrant_pixel_uart_tx.sv
// Directed/randomized bench: RAM model, independent UART decoder and a
// packet-level reference built from the RAM contents.
module tb_quadrant_pixel_uart_tx;

  localparam int         CPB = 4;
  localparam logic [7:0] HDR = 8'hAA;
  localparam int         FRAME_CYC = 19 * 10 * CPB;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] ram [9];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  int          rx_start [$];
  int          frame_err = 0;
  int          pronto_cnt = 0;

  quadrant_pixel_uart_tx_if bus();

  quadrant_pixel_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture RAM, one-cycle read latency
  always @(posedge clk) begin
    int idx;
    idx = int'(bus.addr_line) * 3 + int'(bus.addr_column);
    bus.pixel <= (idx < 9) ? ram[idx] : 16'hDEAD;
  end

  // UART decoder: detect start, sample mid-bit
  always begin : uart_mon
    logic [7:0] b;
    int s;
    @(negedge clk);
    if (bus.tx === 1'b0) begin
      s = cyc;
      repeat (5) @(negedge clk);
      b[0] = bus.tx;
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = bus.tx;
      end
      repeat (CPB) @(negedge clk);
      if (bus.tx !== 1'b1) frame_err++;
      rx_q.push_back(b);
      rx_start.push_back(s);
    end
  end

  always @(negedge clk) if (bus.pronto === 1'b1) pronto_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ram(input bit incr);
    for (int k = 0; k < 9; k++) ram[k] = incr ? 16'(16'h1000 + k) : 16'($urandom_range(0, 65535));
  endtask

  task automatic append_frame();
    exp_q.push_back(HDR);
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(ram[k][15:8]);
      exp_q.push_back(ram[k][7:0]);
    end
  endtask

  task automatic pulse_partida();
    bus.partida = 1'b1;
    @(negedge clk);
    bus.partida = 1'b0;
  endtask

  task automatic wait_pronto(input string tag, output int when, output logic [3:0] addrs);
    int t = 0;
    when = -1;
    addrs = 4'hF;
    while (t < FRAME_CYC + 400) begin
      @(negedge clk);
      t++;
      if (bus.pronto === 1'b1) begin
        when = cyc;
        addrs = {bus.addr_line, bus.addr_column};
        break;
      end
    end
    check({tag, "_pronto_seen"}, 64'(when >= 0), 64'd1);
  endtask

  task automatic check_bytes(input string tag, input int base, input int n);
    check({tag, "_count"}, 64'(rx_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [63:0] got;
      got = (base + i < rx_q.size()) ? 64'(rx_q[base + i]) : 64'hFFFF;
      check($sformatf("%s_byte%0d", tag, i), got, 64'(exp_q[i]));
    end
  endtask

  task automatic check_gaps(input string tag, input int base);
    int g, worst_hi, worst_lo;
    worst_hi = 0;
    worst_lo = 0;
    for (int i = 1; i < 19 && base + i < rx_start.size(); i++) begin
      g = rx_start[base + i] - rx_start[base + i - 1] - 10 * CPB;
      if (g > worst_hi) worst_hi = g;
      if (g < worst_lo) worst_lo = g;
    end
    check({tag, "_gap_le3"}, 64'(worst_hi <= 3 && worst_lo >= 0), 64'd1);
  endtask

  initial begin
    int base, p0, pc, pc1;
    logic [3:0] al;
    logic [39:0] obs_w, exp_w;
    logic [7:0] hv;
    bit seen;

    // 1: reset state
    rst_n = 1'b0;
    bus.partida = 1'b0;
    fill_ram(1'b1);
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(bus.tx), 64'd1);
    check("rst_ocupado", 64'(bus.ocupado), 64'd0);
    check("rst_pronto", 64'(bus.pronto), 64'd0);
    check("rst_addr", 64'({bus.addr_line, bus.addr_column}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 2 + 3: incrementing pixels, header bit timing
    exp_q.delete();
    append_frame();
    base = rx_q.size();
    p0 = pronto_cnt;
    pulse_partida();
    check("f1_ocupado", 64'(bus.ocupado), 64'd1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (bus.tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    check("f1_start_seen", 64'(seen), 64'd1);
    hv = HDR;
    for (int j = 0; j < 40; j++) begin
      int b;
      b = j / CPB;
      exp_w[j] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : hv[b - 1];
      obs_w[j] = bus.tx;
      if (j < 39) @(negedge clk);
    end
    check("hdr_bit_timing", 64'(obs_w), 64'(exp_w));
    wait_pronto("f1", pc, al);
    check("f1_done_addr", 64'(al), 64'd0);
    check("f1_done_ocupado", 64'(bus.ocupado), 64'd0);
    repeat (60) @(negedge clk);
    check_bytes("f1", base, 19);
    check_gaps("f1", base);
    if (base + 18 < rx_start.size())
      check("f1_pronto_after_stop", 64'(pc - (rx_start[base + 18] + 10 * CPB) >= 0 &&
                                        pc - (rx_start[base + 18] + 10 * CPB) <= 3), 64'd1);
    check("f1_pronto_once", 64'(pronto_cnt - p0), 64'd1);

    // 4: partida during byte 5 is ignored
    fill_ram(1'b0);
    exp_q.delete();
    append_frame();
    base = rx_q.size();
    p0 = pronto_cnt;
    pulse_partida();
    for (int t = 0; t < 6 * 10 * CPB && rx_q.size() < base + 4; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("f2_busy_at_repulse", 64'(bus.ocupado), 64'd1);
    pulse_partida();
    wait_pronto("f2", pc, al);
    repeat (100) @(negedge clk);
    check_bytes("f2", base, 19);
    check("f2_pronto_once", 64'(pronto_cnt - p0), 64'd1);

    // 5: reset during byte 7, then a full frame from the header
    fill_ram(1'b0);
    pulse_partida();
    for (int t = 0; t < 8 * 10 * CPB && rx_q.size() < base + 19 + 6; t++) @(negedge clk);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", 64'(bus.tx), 64'd1);
    check("abort_ocupado", 64'(bus.ocupado), 64'd0);
    check("abort_addr", 64'({bus.addr_line, bus.addr_column}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    fill_ram(1'b0);
    exp_q.delete();
    append_frame();
    base = rx_q.size();
    pulse_partida();
    wait_pronto("f3", pc, al);
    repeat (60) @(negedge clk);
    check_bytes("f3", base, 19);
    check_gaps("f3", base);

    // 6: partida held high -> two back-to-back frames
    fill_ram(1'b0);
    exp_q.delete();
    append_frame();
    append_frame();
    base = rx_q.size();
    bus.partida = 1'b1;
    wait_pronto("f4a", pc1, al);
    check("f4a_done_addr", 64'(al), 64'd0);
    wait_pronto("f4b", pc, al);
    bus.partida = 1'b0;
    repeat (100) @(negedge clk);
    check_bytes("f4", base, 38);
    if (base + 19 < rx_start.size())
      check("f4_idle_before_restart", 64'(rx_start[base + 19] - pc1 >= 2), 64'd1);
    check("framing_errors", 64'(frame_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
